// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers.
// Pointer width carries one extra wrap bit above the address.
package cdc_fifo_pkg;

  function automatic int ptr_width(input int log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Binary to reflected-Gray converter; purely combinational, no backpressure.
module binary_to_gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/cdc_fifo_gray_rd_ctrl_gray_sync.sv
// Reset-to-0 flop chain for a Gray pointer crossing into this clock; STAGES cycles latency.
// No logic between stages so each bit resolves metastability independently; no backpressure.
module gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '{default: '0};
    end else begin
      r_sync[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/gray_to_binary.sv
// Reflected-Gray to binary converter; purely combinational, no backpressure.
module gray_to_binary #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    bin_o[W-1] = gray_i[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/cdc_fifo_gray_rd_ctrl.sv
// Read-side pointer controller of a dual-clock FIFO; writes visible SYNC_STAGES cycles late, pops on valid&ready.
// Optional integrity checker on the synced write pointer enabled by CDC_FIFO_GRAY_CHECK_EN.
module cdc_fifo_gray_rd_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int LOG_DEPTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [ptr_width(LOG_DEPTH)-1:0]   wptr_gray_async_i,
  output logic [ptr_width(LOG_DEPTH)-1:0]   rptr_gray_o,
  output logic [LOG_DEPTH-1:0]              rd_addr_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [ptr_width(LOG_DEPTH)-1:0]   fill_o,
  output logic                              empty_o,
  output logic                              err_o
);

  localparam int PW = ptr_width(LOG_DEPTH);
  localparam logic [PW-1:0] DEPTH = PW'(2 ** LOG_DEPTH);

  logic [PW-1:0] w_wptr_gray_s;
  logic [PW-1:0] w_wptr_bin_s;
  logic [PW-1:0] r_rptr_bin;
  logic [PW-1:0] r_rptr_gray;
  logic [PW-1:0] w_rptr_bin_next;
  logic [PW-1:0] w_rptr_gray_next;
  logic          w_pop;

  gray_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (wptr_gray_async_i),
    .q_o    (w_wptr_gray_s)
  );

  gray_to_binary #(.W(PW)) u_wptr_g2b (
    .gray_i (w_wptr_gray_s),
    .bin_o  (w_wptr_bin_s)
  );

  assign w_pop           = valid_o & ready_i;
  assign w_rptr_bin_next = r_rptr_bin + PW'(w_pop);

  binary_to_gray #(.W(PW)) u_rptr_b2g (
    .bin_i  (w_rptr_bin_next),
    .gray_o (w_rptr_gray_next)
  );

  // Gray copy is registered from the next-state value so the write domain never sees glitches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr_bin  <= '0;
      r_rptr_gray <= '0;
    end else begin
      r_rptr_bin  <= w_rptr_bin_next;
      r_rptr_gray <= w_rptr_gray_next;
    end
  end

  assign rptr_gray_o = r_rptr_gray;
  assign rd_addr_o   = r_rptr_bin[LOG_DEPTH-1:0];
  assign fill_o      = w_wptr_bin_s - r_rptr_bin;
  assign empty_o     = (fill_o == '0);
  assign valid_o     = ~empty_o;

`ifdef CDC_FIFO_GRAY_CHECK_EN
  logic [PW-1:0] r_wptr_gray_prev;
  logic          r_err;
  logic          w_err_det;

  assign w_err_det = ($countones(r_wptr_gray_prev ^ w_wptr_gray_s) > 1) || (fill_o > DEPTH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr_gray_prev <= '0;
      r_err            <= 1'b0;
    end else begin
      r_wptr_gray_prev <= w_wptr_gray_s;
      r_err            <= r_err | w_err_det;
    end
  end

  // Flag in the same cycle the bad value appears; the register keeps it sticky.
  assign err_o = r_err | w_err_det;
`else
  assign err_o = 1'b0;
`endif

endmodule
